// File: rtl/xosera_pkg.sv
// Shared definitions for the tile memory arbiter: CPU FSM states and the
// starvation threshold used when TILEMEM_ARB_STARVE_EN is defined.
package xosera_pkg;

  localparam int TILEMEM_STARVE_CYCLES = 16;
  localparam int TILEMEM_STARVE_W      = $clog2(TILEMEM_STARVE_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2,
    WR_DONE = 2'd3
  } cpu_state_t;

endpackage

// File: rtl/tilemem_arb.sv
// Tile memory arbiter: video owns the read port with strict priority, the CPU
// uses the write port freely. Optional macro TILEMEM_ARB_STARVE_EN bounds CPU read wait.
module tilemem_arb
  import xosera_pkg::*;
#(
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              vid_req_i,
  input  logic [AWIDTH-1:0] vid_addr_i,
  output logic              vid_valid_o,
  output logic [15:0]       vid_data_o,
  input  logic              cpu_req_i,
  input  logic              cpu_wr_i,
  input  logic [AWIDTH-1:0] cpu_addr_i,
  input  logic [15:0]       cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [15:0]       cpu_rdata_o,
  output logic              tm_rd_en_o,
  output logic [AWIDTH-1:0] tm_rd_addr_o,
  input  logic [15:0]       tm_rd_data_i,
  output logic              tm_wr_en_o,
  output logic [AWIDTH-1:0] tm_wr_addr_o,
  output logic [15:0]       tm_wr_data_o
);

  cpu_state_t        state_r;
  logic [AWIDTH-1:0] cpu_addr_r;
  logic [15:0]       cpu_rdata_r;
  logic              cpu_ack_r;
  logic              vid_valid_r;

  logic              starve_s;
  logic              cpu_issue_s;
  logic              vid_grant_s;
  logic              wr_cap_s;

`ifdef TILEMEM_ARB_STARVE_EN
  logic [TILEMEM_STARVE_W-1:0] starve_cnt_r;

  // Counts consecutive RD_WAIT cycles lost to video; cleared once the CPU read issues.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt_r <= '0;
    end else if (state_r == RD_WAIT && !cpu_issue_s) begin
      starve_cnt_r <= starve_cnt_r + TILEMEM_STARVE_W'(1);
    end else begin
      starve_cnt_r <= '0;
    end
  end
`endif

  // Read-port arbitration and write-port drive; both ports are quiet in reset.
  always_comb begin
    starve_s = 1'b0;
`ifdef TILEMEM_ARB_STARVE_EN
    starve_s = (state_r == RD_WAIT) &&
               (starve_cnt_r == TILEMEM_STARVE_W'(TILEMEM_STARVE_CYCLES - 1));
`endif
    cpu_issue_s  = reset_n_i && (state_r == RD_WAIT) && (!vid_req_i || starve_s);
    vid_grant_s  = reset_n_i && vid_req_i && !cpu_issue_s;
    wr_cap_s     = reset_n_i && (state_r == IDLE) && cpu_req_i && cpu_wr_i;

    tm_rd_en_o   = vid_grant_s || cpu_issue_s;
    tm_rd_addr_o = cpu_issue_s ? cpu_addr_r : vid_addr_i;
    tm_wr_en_o   = wr_cap_s;
    tm_wr_addr_o = cpu_addr_i;
    tm_wr_data_o = cpu_wdata_i;

    vid_valid_o  = vid_valid_r;
    vid_data_o   = vid_valid_r ? tm_rd_data_i : 16'h0000;
    cpu_ack_o    = cpu_ack_r;
    // Memory data lands in RD_DATA, so it is forwarded during the ack cycle.
    cpu_rdata_o  = (state_r == RD_DATA) ? tm_rd_data_i : cpu_rdata_r;
  end

  // CPU transaction FSM with registered ack and video valid.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      cpu_addr_r  <= '0;
      cpu_rdata_r <= 16'h0000;
      cpu_ack_r   <= 1'b0;
      vid_valid_r <= 1'b0;
    end else begin
      vid_valid_r <= vid_grant_s;
      cpu_ack_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cpu_req_i) begin
            cpu_addr_r <= cpu_addr_i;
            if (cpu_wr_i) begin
              state_r   <= WR_DONE;
              cpu_ack_r <= 1'b1;
            end else begin
              state_r <= RD_WAIT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_WAIT: begin
          if (cpu_issue_s) begin
            state_r   <= RD_DATA;
            cpu_ack_r <= 1'b1;
          end else begin
            state_r <= RD_WAIT;
          end
        end
        RD_DATA: begin
          cpu_rdata_r <= tm_rd_data_i;
          state_r     <= IDLE;
        end
        WR_DONE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tilemem_arb.sv
// Randomized scoreboard bench for tilemem_arb with a behavioural tile memory
// and a cycle-stamped reference model; honours TILEMEM_ARB_STARVE_EN.
module tb_tilemem_arb;

`ifdef TILEMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        vid_req_i = 1'b0;
  logic [11:0] vid_addr_i = 12'h000;
  logic        vid_valid_o;
  logic [15:0] vid_data_o;
  logic        cpu_req_i = 1'b0;
  logic        cpu_wr_i = 1'b0;
  logic [11:0] cpu_addr_i = 12'h000;
  logic [15:0] cpu_wdata_i = 16'h0000;
  logic        cpu_ack_o;
  logic [15:0] cpu_rdata_o;
  logic        tm_rd_en_o;
  logic [11:0] tm_rd_addr_o;
  logic [15:0] tm_rd_data_i = 16'h0000;
  logic        tm_wr_en_o;
  logic [11:0] tm_wr_addr_o;
  logic [15:0] tm_wr_data_o;

  tilemem_arb #(.AWIDTH(12)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i),
    .vid_valid_o(vid_valid_o), .vid_data_o(vid_data_o),
    .cpu_req_i(cpu_req_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
    .tm_rd_en_o(tm_rd_en_o), .tm_rd_addr_o(tm_rd_addr_o), .tm_rd_data_i(tm_rd_data_i),
    .tm_wr_en_o(tm_wr_en_o), .tm_wr_addr_o(tm_wr_addr_o), .tm_wr_data_o(tm_wr_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural tile memory: registered read returning pre-write contents.
  logic [15:0] mem [0:4095];
  always @(posedge clk) begin
    if (tm_rd_en_o) tm_rd_data_i <= mem[tm_rd_addr_o];
    if (tm_wr_en_o) mem[tm_wr_addr_o] <= tm_wr_data_o;
  end

  typedef struct { int cyc; logic [15:0] data; } vid_exp_t;
  typedef struct { int cyc; logic is_rd; logic [15:0] data; } ack_exp_t;
  typedef struct {
    logic rst; logic rd_en; logic [11:0] rd_addr;
    logic wr_en; logic [11:0] wr_addr; logic [15:0] wr_data;
  } cyc_exp_t;

  vid_exp_t vid_q[$];
  ack_exp_t ack_q[$];
  cyc_exp_t cyc_q[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state (abstract view of the CPU transaction).
  logic [15:0] ref_mem [0:4095];
  bit          rd_pending = 1'b0;
  int          waited = 0;
  int          cpu_free_at = 0;
  logic [11:0] cpu_a = 12'h000;

  task automatic step(input bit rst, input bit vreq, input logic [11:0] va,
                      input bit creq, input bit cwr, input logic [11:0] ca,
                      input logic [15:0] cd);
    cyc_exp_t e;
    bit issue;
    @(posedge clk);
    #1;
    reset_n_i   = !rst;
    vid_req_i   = vreq;
    vid_addr_i  = va;
    cpu_req_i   = creq;
    cpu_wr_i    = cwr;
    cpu_addr_i  = ca;
    cpu_wdata_i = cd;
    e = '{rst: rst, rd_en: 1'b0, rd_addr: 12'h000, wr_en: 1'b0, wr_addr: 12'h000, wr_data: 16'h0000};
    issue = 1'b0;
    if (rst) begin
      rd_pending  = 1'b0;
      cpu_free_at = cyc;
      vid_q.delete();
      ack_q.delete();
    end else begin
      if (rd_pending) begin
        issue = !vreq || (STARVE && waited == 15);
        if (issue) begin
          e.rd_en = 1'b1;
          e.rd_addr = cpu_a;
          ack_q.push_back('{cyc: cyc + 1, is_rd: 1'b1, data: ref_mem[cpu_a]});
          rd_pending  = 1'b0;
          cpu_free_at = cyc + 2;
        end else begin
          waited++;
        end
      end else if (cyc >= cpu_free_at && creq) begin
        cpu_a = ca;
        if (cwr) begin
          e.wr_en = 1'b1; e.wr_addr = ca; e.wr_data = cd;
          ack_q.push_back('{cyc: cyc + 1, is_rd: 1'b0, data: 16'h0000});
          cpu_free_at = cyc + 2;
        end else begin
          rd_pending = 1'b1;
          waited = 0;
        end
      end
      if (vreq && !issue) begin
        e.rd_en = 1'b1;
        e.rd_addr = va;
        vid_q.push_back('{cyc: cyc + 1, data: ref_mem[va]});
      end
      if (e.wr_en) ref_mem[ca] = cd;
    end
    cyc_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 12'h000, 0, 0, 12'h000, 16'h0000);
  endtask

  // Monitor: compares DUT outputs against queued expectations away from the active edge.
  cyc_exp_t me;
  vid_exp_t mv;
  ack_exp_t ma;
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      me = cyc_q.pop_front();
      if (me.rst) begin
        chk("rst_rd_en", {31'd0, tm_rd_en_o}, 32'd0);
        chk("rst_wr_en", {31'd0, tm_wr_en_o}, 32'd0);
        chk("rst_ack", {31'd0, cpu_ack_o}, 32'd0);
        chk("rst_vvalid", {31'd0, vid_valid_o}, 32'd0);
        chk("rst_rdata", {16'd0, cpu_rdata_o}, 32'd0);
        chk("rst_vdata", {16'd0, vid_data_o}, 32'd0);
      end else begin
        chk("rd_en", {31'd0, tm_rd_en_o}, {31'd0, me.rd_en});
        if (me.rd_en) chk("rd_addr", {20'd0, tm_rd_addr_o}, {20'd0, me.rd_addr});
        chk("wr_en", {31'd0, tm_wr_en_o}, {31'd0, me.wr_en});
        if (me.wr_en) begin
          chk("wr_addr", {20'd0, tm_wr_addr_o}, {20'd0, me.wr_addr});
          chk("wr_data", {16'd0, tm_wr_data_o}, {16'd0, me.wr_data});
        end
      end
    end
    if (vid_q.size() > 0 && vid_q[0].cyc <= cyc) begin
      mv = vid_q.pop_front();
      chk("vid_valid", {31'd0, vid_valid_o}, 32'd1);
      chk("vid_data", {16'd0, vid_data_o}, {16'd0, mv.data});
    end else begin
      chk("vid_valid_idle", {31'd0, vid_valid_o}, 32'd0);
    end
    if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
      ma = ack_q.pop_front();
      chk("cpu_ack", {31'd0, cpu_ack_o}, 32'd1);
      if (ma.is_rd) chk("cpu_rdata", {16'd0, cpu_rdata_o}, {16'd0, ma.data});
    end else begin
      chk("cpu_ack_idle", {31'd0, cpu_ack_o}, 32'd0);
    end
  end

  logic [15:0] v;
  initial begin
    for (int i = 0; i < 4096; i++) begin
      v = 16'(i * 935) ^ 16'h5C3E;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[12'h010] = 16'h1234;
    ref_mem[12'h010] = 16'h1234;

    for (int i = 0; i < 3; i++) step(1, 1, 12'h010, 1, 0, 12'h001, 16'h0000);
    idle(2);

    // Single video read with an idle CPU.
    step(0, 1, 12'h010, 0, 0, 12'h000, 16'h0000);
    idle(2);

    // Write alongside continuous video reads.
    for (int i = 0; i < 6; i++)
      step(0, 1, 12'(12'h020 + i), (i < 2), 1, 12'h123, 16'hBEEF);
    idle(2);

    // Read with no video, then read with video busy for 5 cycles.
    step(0, 0, 12'h000, 1, 0, 12'h123, 16'h0000);
    idle(4);
    step(0, 0, 12'h000, 1, 0, 12'h123, 16'h0000);
    for (int i = 0; i < 5; i++) step(0, 1, 12'(12'h040 + i), 0, 0, 12'h000, 16'h0000);
    idle(4);

    // Read under continuous video load.
    step(0, 1, 12'h050, 1, 0, 12'h123, 16'h0000);
    for (int i = 0; i < 40; i++) step(0, 1, 12'(12'h051 + i), 0, 0, 12'h000, 16'h0000);
    idle(4);

    // Reset while the read waits, then a normal read.
    step(0, 1, 12'h060, 1, 0, 12'h0AB, 16'h0000);
    for (int i = 0; i < 3; i++) step(0, 1, 12'h061, 0, 0, 12'h000, 16'h0000);
    for (int i = 0; i < 2; i++) step(1, 1, 12'h062, 1, 0, 12'h0AB, 16'h0000);
    idle(3);
    step(0, 0, 12'h000, 1, 0, 12'h0AB, 16'h0000);
    idle(4);

    // Write collides with a video read of the same address.
    step(0, 1, 12'h200, 1, 1, 12'h200, 16'h5555);
    step(0, 1, 12'h200, 0, 0, 12'h000, 16'h0000);
    idle(3);

    // Randomized mix; later part leans on heavy video load.
    for (int i = 0; i < 800; i++) begin
      bit vr;
      vr = (i < 400) ? ($urandom_range(3) != 0) : ($urandom_range(19) != 0);
      step(0, vr, 12'($urandom_range(63)), $urandom_range(1) == 1,
           $urandom_range(1) == 1, 12'($urandom_range(63)), 16'($urandom));
    end
    idle(40);

    chk("vid_q_empty", vid_q.size(), 32'd0);
    chk("ack_q_empty", ack_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tilemem_arb.md
TILEMEM_ARB -- requirements
Module: tilemem_arb

Interface
REQ-001 SHALL have parameter AWIDTH, default 12: tile memory word-address width.
REQ-002 SHALL have port clk  input  1  sole clock; the memory read and write clocks are both driven from it.
REQ-003 SHALL have port reset_n_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have port vid_req_i  input  1  video fetch read request, one word per cycle.
REQ-005 SHALL have port vid_addr_i  input  AWIDTH  video read address.
REQ-006 SHALL have port vid_valid_o  output  1  vid_data_o valid; refers to the request made on the previous cycle.
REQ-007 SHALL have port vid_data_o  output  16  video read data.
REQ-008 SHALL have port cpu_req_i  input  1  CPU access request, a level.
REQ-009 SHALL have port cpu_wr_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port cpu_addr_i  input  AWIDTH  CPU address.
REQ-011 SHALL have port cpu_wdata_i  input  16  CPU write data.
REQ-012 SHALL have port cpu_ack_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have port cpu_rdata_o  output  16  CPU read data, held until the next read completes.
REQ-014 SHALL have ports tm_rd_en_o (1), tm_rd_addr_o (AWIDTH) and tm_rd_data_i (16); these drive the tile memory read port, whose data returns one cycle after enable.
REQ-015 SHALL have ports tm_wr_en_o (1), tm_wr_addr_o (AWIDTH) and tm_wr_data_o (16); these drive the tile memory write port.

Function
REQ-016 SHALL give video strict priority on the read port: when vid_req_i=1, tm_rd_en_o=1 and tm_rd_addr_o=vid_addr_i in the same cycle (combinational).
REQ-017 SHALL assert vid_valid_o exactly one cycle after a video grant, with vid_data_o=tm_rd_data_i.
REQ-018 SHALL run a CPU FSM with states IDLE, RD_WAIT, RD_DATA, WR_DONE, and SHALL capture addr/wdata/wr in IDLE when cpu_req_i=1.
REQ-019 SHALL, for a write, issue tm_wr_en_o in the capture cycle, move IDLE->WR_DONE, pulse cpu_ack_o in WR_DONE, then return to IDLE.
REQ-020 SHALL let a write proceed in the same cycle as a video read, because the ports are independent.
REQ-021 SHALL, for a read, move IDLE->RD_WAIT and hold in RD_WAIT while vid_req_i=1.
REQ-022 SHALL, in RD_WAIT with vid_req_i=0, issue the CPU read and move to RD_DATA; the minimum read latency is 2 cycles after capture.
REQ-023 SHALL, in RD_DATA, load cpu_rdata_o from tm_rd_data_i, pulse cpu_ack_o and return to IDLE.
REQ-024 SHALL not re-sample a request until the cycle after the ack; deasserting cpu_req_i mid-transaction is ignored and the transaction completes.
REQ-025 SHALL return old data to a video read that coincides with a write to the same address, and SHALL not bypass the write data.
REQ-026 SHALL drive tm_wr_en_o only in the capture cycle of a write and tm_rd_en_o only on a grant; otherwise both are 0.

Reset
REQ-027 SHALL, while reset_n_i=0, force vid_valid_o, cpu_ack_o, tm_rd_en_o and tm_wr_en_o to 0, cpu_rdata_o and vid_data_o to 16'h0000, the FSM to IDLE and the starvation counter to 0.
REQ-028 SHALL abandon an in-flight CPU transaction on reset, with no ack pulse afterwards.

Configuration
REQ-029 SHALL implement the macro TILEMEM_ARB_STARVE_EN.
REQ-030 SHALL, when TILEMEM_ARB_STARVE_EN is defined, count consecutive cycles spent in RD_WAIT. On reaching TILEMEM_STARVE_CYCLES (16), the CPU takes the read port for one cycle regardless of vid_req_i. That video request is not granted, vid_valid_o=0 on the following cycle, and the counter is cleared.
REQ-031 SHALL, when TILEMEM_ARB_STARVE_EN is undefined, implement no counter; CPU reads wait indefinitely under continuous video load.

Structure
REQ-032 SHALL place TILEMEM_STARVE_CYCLES and the CPU FSM state enum typedef in xosera_pkg.
REQ-033 SHALL contain no sub-module; tilemem is instantiated beside tilemem_arb by the parent.

Verification
REQ-034 SHALL cover: vid_req_i=1 at addr 0x010 in an idle CPU -> tm_rd_en_o same cycle, vid_valid_o=1 next cycle with the preloaded word.
REQ-035 SHALL cover: CPU write 0xBEEF to 0x123 alongside continuous video reads -> tm_wr_en_o in the capture cycle, ack one cycle later, video never stalled.
REQ-036 SHALL cover: CPU read of 0x123 with vid_req_i=0 -> ack 2 cycles after capture with cpu_rdata_o=0xBEEF; with video busy 5 cycles, ack 7 cycles after capture.
REQ-037 SHALL cover: with TILEMEM_ARB_STARVE_EN and vid_req_i held at 1, a CPU read -> granted on the 16th RD_WAIT cycle, a single vid_valid_o=0 gap, then ack; without the macro, no ack is ever seen.
REQ-038 SHALL cover: reset_n_i pulsed low while in RD_WAIT -> all outputs 0 immediately, no ack, next request serviced normally.
REQ-039 SHALL cover: write 0x5555 to 0x200 while video reads 0x200 in the same cycle -> video receives the old value; a video read the next cycle receives 0x5555.
